brdec_ras_pipe: RTL and testbench

- Parametrised next-generation fetch-bundle branch pre-decoder for the F1->F2 boundary.
- Decodes FETCH_W Alpha instructions and selects the first control-flow instruction in the bundle.
- Owns a speculative circular return-address stack (RAS) with flush-time pointer restore.
- Registers the result into F2 behind a valid/ready handshake; feeds BTB write and next-PC logic.

---
 rtl/brdec_ras_pipe_if.sv | 39 +++
 rtl/brdec_ras_pipe.sv | 155 +++++++++++++++
 tb/tb_brdec_ras_pipe.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/brdec_ras_pipe_if.sv
// F1 -> F2 handshake bundle of the branch pre-decoder.
// slave is the decoder, master is the fetch-side driver/consumer.
interface brdec_ras_pipe_if #(
    parameter int FETCH_W   = 8,
    parameter int RAS_DEPTH = 8,
    parameter int PC_W      = 64
);
    localparam int PW = $clog2(FETCH_W);
    localparam int RW = $clog2(RAS_DEPTH);

    logic                  f1_vld_i;
    logic                  f1_rdy_o;
    logic [PC_W-1:0]       pc_f1_i;
    logic [32*FETCH_W-1:0] inst_f1_i;
    logic                  flush_vld_i;
    logic [RW-1:0]         flush_rasptr_i;
    logic                  f2_vld_o;
    logic                  f2_rdy_i;
    logic [PC_W-1:0]       pc_f2_o;
    logic                  brext_f2_o;
    logic [PW-1:0]         brpos_f2_o;
    logic [1:0]            brtyp_f2_o;
    logic [PC_W-1:0]       brtar_f2_o;
    logic [1:0]            rasctl_f2_o;
    logic [RW-1:0]         rasptr_f2_o;
    logic [FETCH_W-1:0]    instvld_f2_o;

    modport slave (
        input  f1_vld_i, pc_f1_i, inst_f1_i, flush_vld_i, flush_rasptr_i, f2_rdy_i,
        output f1_rdy_o, f2_vld_o, pc_f2_o, brext_f2_o, brpos_f2_o, brtyp_f2_o,
               brtar_f2_o, rasctl_f2_o, rasptr_f2_o, instvld_f2_o
    );

    modport master (
        output f1_vld_i, pc_f1_i, inst_f1_i, flush_vld_i, flush_rasptr_i, f2_rdy_i,
        input  f1_rdy_o, f2_vld_o, pc_f2_o, brext_f2_o, brpos_f2_o, brtyp_f2_o,
               brtar_f2_o, rasctl_f2_o, rasptr_f2_o, instvld_f2_o
    );
endinterface

// File: rtl/brdec_ras_pipe.sv
// Fetch-bundle branch pre-decoder: per-slot Alpha control-flow decode, first-branch
// select, speculative circular return-address stack and a 1-deep F2 output register.
module brdec_slot #(
    parameter int PC_W = 64
) (
    input  logic [31:0]     inst,
    input  logic [PC_W-1:0] pc,
    output logic            is_br,
    output logic [1:0]      typ,
    output logic [1:0]      ctl,
    output logic [PC_W-1:0] tar,
    output logic [PC_W-1:0] link
);
    logic [5:0]      opc;
    logic [PC_W-1:0] disp;

    always_comb begin
        opc   = inst[31:26];
        disp  = {{(PC_W-21){inst[20]}}, inst[20:0]};
        link  = pc + PC_W'(4);
        is_br = 1'b0;
        typ   = 2'b00;
        ctl   = 2'b00;
        tar   = '0;
        // 0x30..0x3F are all PC-relative branches; BR/BSR are the unconditional pair
        if (opc[5:4] == 2'b11) begin
            is_br = 1'b1;
            tar   = link + (disp << 2);
            if (opc == 6'h30) begin
                typ = 2'b01;
            end else if (opc == 6'h34) begin
                typ = 2'b01;
                ctl = 2'b01;
            end
        end else if (opc == 6'h1A) begin
            is_br = 1'b1;
            case (inst[15:14])
                2'b00:   typ = 2'b10;
                2'b01:   begin typ = 2'b10; ctl = 2'b01; end
                2'b10:   begin typ = 2'b11; ctl = 2'b10; end
                default: begin typ = 2'b11; ctl = 2'b11; end
            endcase
        end
    end
endmodule

module brdec_ras_pipe #(
    parameter int FETCH_W   = 8,
    parameter int RAS_DEPTH = 8,
    parameter int PC_W      = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    brdec_ras_pipe_if.slave bus
);
    localparam int PW = $clog2(FETCH_W);
    localparam int RW = $clog2(RAS_DEPTH);
    localparam logic [RW-1:0] ONE = RW'(1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic               brext;
        logic [PW-1:0]      brpos;
        logic [1:0]         brtyp;
        logic [PC_W-1:0]    brtar;
        logic [1:0]         rasctl;
        logic [RW-1:0]      rasptr;
        logic [FETCH_W-1:0] instvld;
    } f2_t;

    logic [FETCH_W-1:0]                 slot_br;
    logic [FETCH_W-1:0][1:0]            slot_typ, slot_ctl;
    logic [FETCH_W-1:0][PC_W-1:0]       slot_tar, slot_link;
    logic [RAS_DEPTH-1:0][PC_W-1:0]     ras;
    logic [RW-1:0]                      ptr;
    logic [PC_W-1:0]                    link;
    f2_t                                nxt, f2_q;
    logic                               f2_vld_q, f1_rdy, accept;

    genvar k;
    generate
        for (k = 0; k < FETCH_W; k++) begin : g_slot
            brdec_slot #(.PC_W(PC_W)) u_slot (
                .inst  (bus.inst_f1_i[32*k +: 32]),
                .pc    (bus.pc_f1_i + PC_W'(4*k)),
                .is_br (slot_br[k]),
                .typ   (slot_typ[k]),
                .ctl   (slot_ctl[k]),
                .tar   (slot_tar[k]),
                .link  (slot_link[k])
            );
        end
    endgenerate

    // Descending scan so the lowest-index branch is the last (winning) assignment
    always_comb begin
        nxt        = '0;
        nxt.pc     = bus.pc_f1_i;
        nxt.rasptr = ptr;
        link       = '0;
        for (int i = FETCH_W-1; i >= 0; i--) begin
            if (slot_br[i]) begin
                nxt.brext  = 1'b1;
                nxt.brpos  = PW'(i);
                nxt.brtyp  = slot_typ[i];
                nxt.brtar  = slot_tar[i];
                nxt.rasctl = slot_ctl[i];
                link       = slot_link[i];
            end
        end
        if (nxt.brtyp == 2'b11) nxt.brtar = ras[ptr];
        for (int i = 0; i < FETCH_W; i++)
            nxt.instvld[i] = !nxt.brext || (PW'(i) <= nxt.brpos);
    end

    assign f1_rdy = !f2_vld_q || bus.f2_rdy_i;
    assign accept = bus.f1_vld_i && f1_rdy && !bus.flush_vld_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f2_q     <= '0;
            f2_vld_q <= 1'b0;
            ptr      <= '0;
            ras      <= '0;
        end else if (bus.flush_vld_i) begin
            f2_vld_q <= 1'b0;
            ptr      <= bus.flush_rasptr_i;
        end else if (accept) begin
            f2_q     <= nxt;
            f2_vld_q <= 1'b1;
            case (nxt.rasctl)
                2'b01: begin
                    ras[ptr + ONE] <= link;
                    ptr            <= ptr + ONE;
                end
                2'b10: ptr <= ptr - ONE;
                2'b11: ras[ptr] <= link;
                default: ;
            endcase
        end else if (bus.f2_rdy_i) begin
            f2_vld_q <= 1'b0;
        end
    end

    assign bus.f1_rdy_o     = f1_rdy;
    assign bus.f2_vld_o     = f2_vld_q;
    assign bus.pc_f2_o      = f2_q.pc;
    assign bus.brext_f2_o   = f2_q.brext;
    assign bus.brpos_f2_o   = f2_q.brpos;
    assign bus.brtyp_f2_o   = f2_q.brtyp;
    assign bus.brtar_f2_o   = f2_q.brtar;
    assign bus.rasctl_f2_o  = f2_q.rasctl;
    assign bus.rasptr_f2_o  = f2_q.rasptr;
    assign bus.instvld_f2_o = f2_q.instvld;
endmodule

// File: tb/tb_brdec_ras_pipe.sv
// Directed bench for brdec_ras_pipe (FETCH_W=8, RAS_DEPTH=4): stimulus pushes
// hand-computed F2 results into a queue, a negedge monitor pops on each F2 handshake.
module tb_brdec_ras_pipe;
    localparam logic [31:0] NOP    = 32'h47FF041F;
    localparam logic [31:0] RET    = 32'h6BFA8001;
    localparam logic [31:0] JMP    = 32'h68000000;
    localparam logic [31:0] JSR    = 32'h68004000;
    localparam logic [31:0] JSR_CO = 32'h6800C000;
    localparam logic [31:0] BSR0   = 32'hD3400000;

    typedef struct {
        logic [63:0] pc;
        logic        brext;
        logic [2:0]  pos;
        logic [1:0]  typ;
        logic [63:0] tar;
        logic [1:0]  ctl;
        logic [1:0]  ptr;
        logic [7:0]  vld;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    brdec_ras_pipe_if #(.FETCH_W(8), .RAS_DEPTH(4), .PC_W(64)) bus ();
    brdec_ras_pipe #(.FETCH_W(8), .RAS_DEPTH(4), .PC_W(64)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(logic [63:0] pc, logic brext, logic [2:0] pos, logic [1:0] typ,
                                logic [63:0] tar, logic [1:0] ctl, logic [1:0] ptr, logic [7:0] vld);
        exp_t e;
        e.pc = pc; e.brext = brext; e.pos = pos; e.typ = typ;
        e.tar = tar; e.ctl = ctl; e.ptr = ptr; e.vld = vld;
        return e;
    endfunction

    function automatic logic [255:0] bnd(int s0, logic [31:0] i0, int s1, logic [31:0] i1);
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[32*k +: 32] = NOP;
        if (s1 >= 0) b[32*s1 +: 32] = i1;
        if (s0 >= 0) b[32*s0 +: 32] = i0;
        return b;
    endfunction

    task automatic send(input logic [63:0] pc, input logic [255:0] b, input exp_t e);
        int n = 0;
        bus.pc_f1_i   = pc;
        bus.inst_f1_i = b;
        bus.f1_vld_i  = 1'b1;
        while (!bus.f1_rdy_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            chk("send_timeout", 64'(n), 64'd0);
            bus.f1_vld_i = 1'b0;
            return;
        end
        q.push_back(e);
        @(posedge clk); #1;
        bus.f1_vld_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.f2_vld_o && bus.f2_rdy_i) begin
            if (q.size() == 0) begin
                chk("unexpected_f2", bus.pc_f2_o, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pc_f2",      bus.pc_f2_o,      e.pc);
                chk("brext_f2",   64'(bus.brext_f2_o),   64'(e.brext));
                chk("brpos_f2",   64'(bus.brpos_f2_o),   64'(e.pos));
                chk("brtyp_f2",   64'(bus.brtyp_f2_o),   64'(e.typ));
                chk("brtar_f2",   bus.brtar_f2_o,   e.tar);
                chk("rasctl_f2",  64'(bus.rasctl_f2_o),  64'(e.ctl));
                chk("rasptr_f2",  64'(bus.rasptr_f2_o),  64'(e.ptr));
                chk("instvld_f2", 64'(bus.instvld_f2_o), 64'(e.vld));
            end
        end
    end

    logic [63:0] ret_tar [5] = '{64'h5404, 64'h5304, 64'h5204, 64'h5104, 64'h5404};
    logic [1:0]  ret_ptr [5] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd1};

    initial begin
        bus.f1_vld_i = 1'b0; bus.pc_f1_i = '0; bus.inst_f1_i = '0;
        bus.flush_vld_i = 1'b0; bus.flush_rasptr_i = '0; bus.f2_rdy_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_f2_vld",  64'(bus.f2_vld_o), 64'd0);
        chk("rst_f1_rdy",  64'(bus.f1_rdy_o), 64'd1);
        chk("rst_pc_f2",   bus.pc_f2_o, 64'd0);
        chk("rst_brtar",   bus.brtar_f2_o, 64'd0);
        chk("rst_instvld", 64'(bus.instvld_f2_o), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_f2_vld", 64'(bus.f2_vld_o), 64'd0);

        send(64'h2000, bnd(-1, NOP, -1, NOP), mk(64'h2000, 0, 0, 2'b00, 0, 2'b00, 0, 8'hFF));
        send(64'h1000, bnd(3, BSR0 | 32'h10, 5, 32'hE4000005),
             mk(64'h1000, 1, 3, 2'b01, 64'h1050, 2'b01, 0, 8'h0F));
        send(64'h1020, bnd(0, RET, -1, NOP), mk(64'h1020, 1, 0, 2'b11, 64'h1010, 2'b10, 1, 8'h01));
        send(64'h3000, bnd(7, 32'hE41FFFFF, -1, NOP),
             mk(64'h3000, 1, 7, 2'b00, 64'h301C, 2'b00, 0, 8'hFF));

        // back-pressure: A parks in F2, B waits at F1 for 3 cycles
        @(posedge clk); #1;
        bus.f2_rdy_i = 1'b0;
        send(64'h4000, bnd(-1, NOP, -1, NOP), mk(64'h4000, 0, 0, 2'b00, 0, 2'b00, 0, 8'hFF));
        bus.pc_f1_i = 64'h4020; bus.inst_f1_i = bnd(2, JMP, -1, NOP); bus.f1_vld_i = 1'b1;
        repeat (3) begin
            chk("bp_f1_rdy",  64'(bus.f1_rdy_o), 64'd0);
            chk("bp_f2_vld",  64'(bus.f2_vld_o), 64'd1);
            chk("bp_hold_pc", bus.pc_f2_o, 64'h4000);
            @(posedge clk); #1;
        end
        bus.f2_rdy_i = 1'b1;
        q.push_back(mk(64'h4020, 1, 2, 2'b10, 0, 2'b00, 0, 8'h07));
        @(posedge clk); #1;
        bus.f1_vld_i = 1'b0;

        // overflow then underflow of the 4-entry stack
        for (int i = 0; i < 5; i++)
            send(64'h5000 + 64'(i) * 64'h100, bnd(0, BSR0, -1, NOP),
                 mk(64'h5000 + 64'(i) * 64'h100, 1, 0, 2'b01, 64'h5004 + 64'(i) * 64'h100,
                    2'b01, 2'(i), 8'h01));
        for (int i = 0; i < 5; i++)
            send(64'h6000 + 64'(i) * 64'h100, bnd(0, RET, -1, NOP),
                 mk(64'h6000 + 64'(i) * 64'h100, 1, 0, 2'b11, ret_tar[i], 2'b10, ret_ptr[i], 8'h01));

        send(64'h7000, bnd(1, JSR, 4, RET), mk(64'h7000, 1, 1, 2'b10, 0, 2'b01, 0, 8'h03));
        send(64'h7100, bnd(0, JSR_CO, -1, NOP), mk(64'h7100, 1, 0, 2'b11, 64'h7008, 2'b11, 1, 8'h01));
        send(64'h7200, bnd(0, RET, -1, NOP), mk(64'h7200, 1, 0, 2'b11, 64'h7104, 2'b10, 1, 8'h01));

        // flush with a BSR waiting at F1: bundle dropped, ptr forced to 2
        send(64'h8000, bnd(-1, NOP, -1, NOP), mk(64'h8000, 0, 0, 2'b00, 0, 2'b00, 0, 8'hFF));
        bus.pc_f1_i = 64'h8100; bus.inst_f1_i = bnd(0, BSR0, -1, NOP); bus.f1_vld_i = 1'b1;
        bus.flush_vld_i = 1'b1; bus.flush_rasptr_i = 2'd2;
        @(posedge clk); #1;
        bus.flush_vld_i = 1'b0; bus.f1_vld_i = 1'b0;
        chk("flush_f2_vld", 64'(bus.f2_vld_o), 64'd0);
        send(64'h9000, bnd(0, RET, -1, NOP), mk(64'h9000, 1, 0, 2'b11, 64'h5104, 2'b10, 2, 8'h01));
        send(64'h9100, bnd(0, RET, -1, NOP), mk(64'h9100, 1, 0, 2'b11, 64'h7104, 2'b10, 1, 8'h01));

        // reset with a bundle parked in F2 wipes it and the stack
        @(posedge clk); #1;
        bus.f2_rdy_i = 1'b0;
        send(64'hA000, bnd(-1, NOP, -1, NOP), mk(64'hA000, 0, 0, 2'b00, 0, 2'b00, 0, 8'hFF));
        rst = 1'b1;
        @(posedge clk); #1;
        void'(q.pop_back());
        rst = 1'b0;
        chk("mid_rst_f2_vld", 64'(bus.f2_vld_o), 64'd0);
        chk("mid_rst_pc_f2",  bus.pc_f2_o, 64'd0);
        chk("mid_rst_f1_rdy", 64'(bus.f1_rdy_o), 64'd1);
        bus.f2_rdy_i = 1'b1;
        send(64'hA100, bnd(0, RET, -1, NOP), mk(64'hA100, 1, 0, 2'b11, 64'h0, 2'b10, 0, 8'h01));

        for (int n = 0; n < 50 && q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        chk("queue_drained", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
